mac_sched: RTL and testbench

- Framing and codebook scheduler that sits in front of the beam MAC array.
- Accepts the per-symbol antenna RE stream (valid/sop/eop) and counts REs.
- Issues codebook RAM read addresses per RE group, then delays the data and framing by the RAM latency so codewords and antenna samples reach the MAC array together.
- Polices symbol length, and tags MAC outputs with the symbol index after the MAC pipeline latency.

---
 rtl/mac_sched_pkg.sv | 20 ++
 rtl/mac_sched_if.sv | 43 ++++
 rtl/mac_sched_dly.sv | 23 ++
 rtl/mac_sched.sv | 168 ++++++++++++++++
 tb/tb_mac_sched.sv | 175 +++++++++++++++++
 5 files changed

// File: rtl/mac_sched_pkg.sv
// Shared types for the MAC-array framing/codebook scheduler.
package mac_sched_pkg;

  typedef enum logic [1:0] {IDLE, RUN, DROP} state_t;

  typedef struct packed {
    logic       valid;
    logic       sop;
    logic [3:0] sym;
  } tag_t;

  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic int addr_w(input int nbank, input int ngrp);
    return cnt_w(nbank * ngrp);
  endfunction

endpackage

// File: rtl/mac_sched_if.sv
// RE stream in, codebook read / MAC framing / tags out; master = source, slave = scheduler.
interface mac_sched_if #(
  parameter int DW = 1024,
  parameter int BW = 3,
  parameter int AW = 11
);
  logic [DW-1:0] i_data;
  logic          i_rvalid;
  logic          i_sop;
  logic          i_eop;
  logic [3:0]    i_sym_idx;
  logic          i_cfg_wr;
  logic [BW-1:0] i_cfg_bank;

  logic          o_cb_rd_en;
  logic [AW-1:0] o_cb_rd_addr;
  logic [DW-1:0] o_data;
  logic          o_rvalid;
  logic          o_sop;
  logic          o_eop;
  logic          o_tag_valid;
  logic          o_tag_sop;
  logic [3:0]    o_tag_sym;
  logic          o_err_short;
  logic          o_err_long;
  logic          o_err_sop;
  logic [15:0]   o_sym_cnt;
  logic [15:0]   o_err_cnt;

  modport master (
    output i_data, i_rvalid, i_sop, i_eop, i_sym_idx, i_cfg_wr, i_cfg_bank,
    input  o_cb_rd_en, o_cb_rd_addr, o_data, o_rvalid, o_sop, o_eop,
           o_tag_valid, o_tag_sop, o_tag_sym, o_err_short, o_err_long, o_err_sop,
           o_sym_cnt, o_err_cnt
  );

  modport slave (
    input  i_data, i_rvalid, i_sop, i_eop, i_sym_idx, i_cfg_wr, i_cfg_bank,
    output o_cb_rd_en, o_cb_rd_addr, o_data, o_rvalid, o_sop, o_eop,
           o_tag_valid, o_tag_sop, o_tag_sym, o_err_short, o_err_long, o_err_sop,
           o_sym_cnt, o_err_cnt
  );
endinterface

// File: rtl/mac_sched_dly.sv
// Fixed-depth register delay line, latency D cycles, no backpressure; synchronous clear.
module mac_sched_dly #(
  parameter int W = 8,
  parameter int D = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);
  logic [W-1:0] pipe [D];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < D; i++) pipe[i] <= '0;
    end else begin
      pipe[0] <= d;
      for (int i = 1; i < D; i++) pipe[i] <= pipe[i-1];
    end
  end

  assign q = pipe[D-1];
endmodule

// File: rtl/mac_sched.sv
// Symbol framing policer + codebook address issue; data latency CB_LAT+1, tags +MAC_LAT, no backpressure.
// Optional MAC_SCHED_STATS_EN adds saturating symbol/error counters (tied to 0 otherwise).
module mac_sched
  import mac_sched_pkg::*;
#(
  parameter int NRE        = 3276,
  parameter int RE_PER_GRP = 12,
  parameter int NGRP       = NRE / RE_PER_GRP,
  parameter int NBANK      = 4,
  parameter int CB_LAT     = 2,
  parameter int MAC_LAT    = 8,
  parameter int DW         = 1024
) (
  input  logic     i_clk,
  input  logic     i_reset,
  mac_sched_if.slave bus
);
  localparam int CW = cnt_w(NRE);
  localparam int RW = cnt_w(RE_PER_GRP);
  localparam int GW = cnt_w(NGRP);
  // one spare bit so out-of-range bank requests are representable and get clamped
  localparam int BW = $clog2(NBANK) + 1;
  localparam int AW = addr_w(NBANK, NGRP);
  localparam logic [CW-1:0] LAST_RE  = CW'(NRE - 1);
  localparam logic [RW-1:0] LAST_RIG = RW'(RE_PER_GRP - 1);
  localparam logic [BW-1:0] MAX_BANK = BW'(NBANK - 1);

  state_t        state;
  logic [CW-1:0] re_cnt;
  logic [RW-1:0] re_in_grp;
  logic [GW-1:0] grp;
  logic [BW-1:0] pend_bank, act_bank;
  logic [3:0]    sym;
  logic          rd_en, err_short, err_long, err_sop;
  logic [AW-1:0] rd_addr;

  logic          start, run_beat, acc, last, fwd_eop, grp_start;
  logic          ev_short, ev_long, ev_sop;
  logic [BW-1:0] cfg_bank, pend_eff, bank_eff;
  logic [GW-1:0] grp_eff;
  logic [3:0]    sym_eff;

  always_comb begin
    start     = bus.i_rvalid & bus.i_sop;
    run_beat  = bus.i_rvalid & ~bus.i_sop & (state == RUN);
    acc       = start | run_beat;
    last      = run_beat & (re_cnt == LAST_RE);
    ev_sop    = start & (state == RUN);
    ev_short  = acc & bus.i_eop & ~last;
    ev_long   = last & ~bus.i_eop;
    fwd_eop   = acc & (bus.i_eop | ev_long);
    grp_start = start | (run_beat & (re_in_grp == '0));
    cfg_bank  = (bus.i_cfg_bank > MAX_BANK) ? MAX_BANK : bus.i_cfg_bank;
    pend_eff  = bus.i_cfg_wr ? cfg_bank : pend_bank;
    bank_eff  = start ? pend_eff : act_bank;
    grp_eff   = start ? '0 : grp;
    sym_eff   = acc ? (start ? bus.i_sym_idx : sym) : 4'd0;
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state     <= IDLE;
      re_cnt    <= '0;
      re_in_grp <= '0;
      grp       <= '0;
      pend_bank <= '0;
      act_bank  <= '0;
      sym       <= '0;
      rd_en     <= 1'b0;
      rd_addr   <= '0;
      err_short <= 1'b0;
      err_long  <= 1'b0;
      err_sop   <= 1'b0;
    end else begin
      if (bus.i_cfg_wr) pend_bank <= cfg_bank;
      rd_en <= grp_start;
      if (grp_start) rd_addr <= AW'(bank_eff) * AW'(NGRP) + AW'(grp_eff);
      err_short <= err_short | ev_short;
      err_long  <= err_long | ev_long;
      err_sop   <= err_sop | ev_sop;
      if (start) begin
        act_bank  <= pend_eff;
        sym       <= bus.i_sym_idx;
        re_cnt    <= CW'(1);
        re_in_grp <= (RE_PER_GRP > 1) ? RW'(1) : '0;
        grp       <= (RE_PER_GRP > 1) ? '0 : GW'(1);
        state     <= bus.i_eop ? IDLE : RUN;
      end else if (run_beat) begin
        if (bus.i_eop || last) begin
          state <= ev_long ? DROP : IDLE;
        end else begin
          re_cnt <= re_cnt + CW'(1);
          if (re_in_grp == LAST_RIG) begin
            re_in_grp <= '0;
            grp       <= grp + GW'(1);
          end else begin
            re_in_grp <= re_in_grp + RW'(1);
          end
        end
      end
    end
  end

  assign bus.o_cb_rd_en   = rd_en;
  assign bus.o_cb_rd_addr = rd_addr;
  assign bus.o_err_short  = err_short;
  assign bus.o_err_long   = err_long;
  assign bus.o_err_sop    = err_sop;

  // depth CB_LAT+1 lines the first beat of each group up with the RAM read data
  logic [DW+6:0] dat_q;
  logic          p_vld, p_sop, p_eop;
  logic [3:0]    p_sym;

  mac_sched_dly #(.W(DW + 7), .D(CB_LAT + 1)) u_dat_dly (
    .clk (i_clk),
    .rst (i_reset),
    .d   ({acc, start, fwd_eop, sym_eff, bus.i_data}),
    .q   (dat_q)
  );

  assign {p_vld, p_sop, p_eop, p_sym, bus.o_data} = dat_q;
  assign bus.o_rvalid = p_vld;
  assign bus.o_sop    = p_sop;
  assign bus.o_eop    = p_eop;

  tag_t tag_d, tag_q;

  always_comb begin
    tag_d.valid = p_vld;
    tag_d.sop   = p_sop;
    tag_d.sym   = p_sym;
  end

  mac_sched_dly #(.W($bits(tag_t)), .D(MAC_LAT)) u_tag_dly (
    .clk (i_clk),
    .rst (i_reset),
    .d   (tag_d),
    .q   (tag_q)
  );

  assign bus.o_tag_valid = tag_q.valid;
  assign bus.o_tag_sop   = tag_q.sop;
  assign bus.o_tag_sym   = tag_q.sym;

`ifdef MAC_SCHED_STATS_EN
  logic [15:0] sym_cnt, err_cnt;
  logic [15:0] ev_n;

  always_comb ev_n = 16'(ev_short) + 16'(ev_long) + 16'(ev_sop);

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      sym_cnt <= '0;
      err_cnt <= '0;
    end else begin
      if (start && sym_cnt != 16'hFFFF) sym_cnt <= sym_cnt + 16'd1;
      err_cnt <= (err_cnt > 16'hFFFF - ev_n) ? 16'hFFFF : err_cnt + ev_n;
    end
  end

  assign bus.o_sym_cnt = sym_cnt;
  assign bus.o_err_cnt = err_cnt;
`else
  assign bus.o_sym_cnt = 16'd0;
  assign bus.o_err_cnt = 16'd0;
`endif
endmodule

// File: tb/tb_mac_sched.sv
// Directed + randomized bench for mac_sched against a symbol-level reference model.
module tb_mac_sched;
  localparam int NRE = 48, RPG = 12, NGRP = 4, NBANK = 4, CB_LAT = 2, MAC_LAT = 8;
  localparam int DW = 16, BW = 3, AW = 4, MAXC = 4096;
  localparam int DL = CB_LAT + 1, TL = CB_LAT + 1 + MAC_LAT;

  logic clk = 1'b0;
  logic rst = 1'b0;

  mac_sched_if #(.DW(DW), .BW(BW), .AW(AW)) bus ();

  mac_sched #(
    .NRE(NRE), .RE_PER_GRP(RPG), .NGRP(NGRP), .NBANK(NBANK),
    .CB_LAT(CB_LAT), .MAC_LAT(MAC_LAT), .DW(DW)
  ) dut (
    .i_clk   (clk),
    .i_reset (rst),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  int checks = 0, failures = 0, cyc = 0;
  bit chk_en = 1'b0;

  // expected output per observation cycle
  bit          e_rd [MAXC];
  int          e_addr [MAXC];
  bit          e_vld [MAXC], e_sop [MAXC], e_eop [MAXC];
  bit [DW-1:0] e_dat [MAXC];
  bit          t_vld [MAXC], t_sop [MAXC];
  int          t_sym [MAXC];
  bit [2:0]    e_err [MAXC];
  int          e_sc [MAXC], e_ec [MAXC];

  // reference model: IDLE and DROP behave alike, so only "inside a symbol" matters
  bit       in_sym;
  int       n, bank_act, pend, cur_sym, n_sym, n_err;
  bit [2:0] errs;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s cyc=%0d obs=%0h exp=%0h", tag, cyc, obs, exp);
    end
  endtask

  task automatic check_outputs(input int c);
    chk("rd_en", 32'(bus.o_cb_rd_en), 32'(e_rd[c]));
    if (e_rd[c]) chk("rd_addr", 32'(bus.o_cb_rd_addr), 32'(e_addr[c]));
    chk("rvalid", 32'(bus.o_rvalid), 32'(e_vld[c]));
    chk("sop", 32'(bus.o_sop), 32'(e_sop[c]));
    chk("eop", 32'(bus.o_eop), 32'(e_eop[c]));
    chk("data", 32'(bus.o_data), 32'(e_dat[c]));
    chk("tag_valid", 32'(bus.o_tag_valid), 32'(t_vld[c]));
    chk("tag_sop", 32'(bus.o_tag_sop), 32'(t_sop[c]));
    if (t_vld[c]) chk("tag_sym", 32'(bus.o_tag_sym), 32'(t_sym[c]));
    chk("errs", 32'({bus.o_err_short, bus.o_err_long, bus.o_err_sop}), 32'(e_err[c]));
    chk("sym_cnt", 32'(bus.o_sym_cnt), 32'(e_sc[c]));
    chk("err_cnt", 32'(bus.o_err_cnt), 32'(e_ec[c]));
  endtask

  task automatic step(input bit r, input bit v, input bit s, input bit e,
                      input int sym, input bit cw, input int bank);
    bit [DW-1:0] d;
    bit acc, s_eff, feop, rd;
    int addr;
    @(negedge clk);
    if (chk_en) check_outputs(cyc);
    if (cyc + TL + 1 >= MAXC) begin
      $display("FAIL cycle_budget cyc=%0d limit=%0d", cyc, MAXC);
      $fatal(1);
    end
    d = DW'($urandom);
    rst = r;
    bus.i_rvalid = v; bus.i_sop = s; bus.i_eop = e; bus.i_sym_idx = 4'(sym);
    bus.i_cfg_wr = cw; bus.i_cfg_bank = BW'(bank); bus.i_data = d;
    if (r) begin
      in_sym = 0; n = 0; bank_act = 0; pend = 0; errs = 0; n_sym = 0; n_err = 0;
      for (int k = cyc + 1; k <= cyc + TL; k++) begin
        e_rd[k] = 0; e_vld[k] = 0; e_sop[k] = 0; e_eop[k] = 0; e_dat[k] = '0;
        t_vld[k] = 0; t_sop[k] = 0; t_sym[k] = 0;
      end
      chk_en = 1'b1;
    end else begin
      acc = 0; s_eff = 0; feop = 0; rd = 0; addr = 0;
      if (cw) pend = (bank > NBANK - 1) ? NBANK - 1 : bank;
      if (v && s) begin
        if (in_sym) begin errs[0] = 1; n_err++; end
        acc = 1; s_eff = 1; feop = e; rd = 1;
        bank_act = pend; cur_sym = sym; addr = bank_act * NGRP;
        if (e) begin errs[2] = 1; n_err++; end
        in_sym = !e; n = 1;
      end else if (v && in_sym) begin
        acc = 1;
        if (n % RPG == 0) begin rd = 1; addr = bank_act * NGRP + n / RPG; end
        if (e) begin
          feop = 1; in_sym = 0;
          if (n != NRE - 1) begin errs[2] = 1; n_err++; end
        end else if (n == NRE - 1) begin
          feop = 1; in_sym = 0; errs[1] = 1; n_err++;
        end
        n++;
      end
      n_sym += int'(s_eff);
      e_rd[cyc+1] = rd; e_addr[cyc+1] = addr;
      e_vld[cyc+DL] = acc; e_sop[cyc+DL] = s_eff; e_eop[cyc+DL] = feop; e_dat[cyc+DL] = d;
      t_vld[cyc+TL] = acc; t_sop[cyc+TL] = s_eff; t_sym[cyc+TL] = acc ? cur_sym : 0;
    end
    e_err[cyc+1] = errs;
`ifdef MAC_SCHED_STATS_EN
    e_sc[cyc+1] = n_sym; e_ec[cyc+1] = n_err;
`else
    e_sc[cyc+1] = 0; e_ec[cyc+1] = 0;
`endif
    cyc++;
  endtask

  task automatic idle(input int k);
    repeat (k) step(0, 0, 0, 0, 0, 0, 0);
  endtask

  // gaps: 0 none, 1 alternate idle cycles, 2 random idle bursts
  task automatic sym_run(input int len, input int eop_at, input int sop2_at, input int gaps,
                         input int cfg_at, input int cfg_bank, input int sym, input bit first_sop);
    for (int i = 0; i < len; i++) begin
      if (i > 0 && gaps == 1) idle(1);
      if (i > 0 && gaps == 2 && $urandom_range(0, 2) == 0) idle($urandom_range(1, 3));
      step(0, 1, (i == 0 && first_sop) || (i == sop2_at), (i == eop_at), sym,
           (i == cfg_at), cfg_bank);
    end
  endtask

  initial begin
    int len, eop_at, sop2, cfg_at;
    bus.i_data = '0; bus.i_rvalid = 0; bus.i_sop = 0; bus.i_eop = 0;
    bus.i_sym_idx = '0; bus.i_cfg_wr = 0; bus.i_cfg_bank = '0;
    step(1, 0, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0, 0);
    idle(3);
    step(0, 1, 0, 0, 1, 0, 0);                 // stray beat in IDLE
    sym_run(48, 47, -1, 0, -1, 0, 3, 1);       // normal symbol
    idle(2);
    sym_run(48, 47, -1, 0, 10, 2, 5, 1);       // bank 2 written mid-symbol
    sym_run(48, 47, -1, 0, -1, 0, 6, 1);       // uses bank 2
    sym_run(48, 47, -1, 0, 0, 5, 7, 1);        // bank 5 on sop, clamped to 3
    idle(2);
    sym_run(30, 29, -1, 0, -1, 0, 8, 1);       // short
    sym_run(48, 47, -1, 0, -1, 0, 9, 1);
    sym_run(60, 59, -1, 0, -1, 0, 10, 1);      // long
    idle(2);
    sym_run(67, 66, 19, 0, -1, 0, 11, 1);      // early sop at beat 20
    sym_run(48, 47, -1, 1, 3, 1, 13, 1);       // alternating gaps
    sym_run(1, 0, -1, 0, -1, 0, 14, 1);        // one-beat symbol
    idle(1);
    sym_run(25, -1, -1, 0, -1, 0, 12, 1);      // reset mid-symbol
    step(1, 1, 0, 0, 12, 0, 0);
    sym_run(23, 22, -1, 0, -1, 0, 12, 0);
    idle(2);
    sym_run(48, 47, -1, 0, -1, 0, 15, 1);
    for (int s = 0; s < 14; s++) begin
      len    = $urandom_range(40, 56);
      eop_at = ($urandom_range(0, 3) == 0) ? -1 : len - 1;
      sop2   = ($urandom_range(0, 5) == 0) ? $urandom_range(1, len - 1) : -1;
      cfg_at = ($urandom_range(0, 2) == 0) ? $urandom_range(0, len - 1) : -1;
      sym_run(len, eop_at, sop2, 2, cfg_at, $urandom_range(0, 7), $urandom_range(0, 15), 1);
      repeat ($urandom_range(0, 3)) step(0, 1, 0, $urandom_range(0, 1), 0, 0, 0);
      idle($urandom_range(0, 3));
    end
    idle(TL + 4);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
